shift_sequencer: RTL and testbench



---
 rtl/shifter_pkg.sv | 16 +
 rtl/shift_one_step.sv | 18 +
 rtl/shift_sequencer.sv | 117 +++++++++++
 tb/tb_shift_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: shared state encoding, direction codes and default sizes for the iterative shifter
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AMT_W = 5;

endpackage

// File: rtl/shift_one_step.sv
// shift_one_step: combinational single-bit shift; right shifts insert the fill bit, left shifts insert zero
module shift_one_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out
);

    // one position toward LSB (right) or MSB (left)
    always_comb begin
        data_out = (dir == SH_RIGHT) ? {fill, data_in[WIDTH-1:1]} : {data_in[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative multi-cycle shifter with valid/ready on both sides.
// Build option SHIFT_SEQ_QUAD_STEP_EN: shift four bits per cycle while at least four remain.
module shift_sequencer
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [AMT_W-1:0] IN_AMT,
    input  logic             SH_DIR,
    input  logic             ARITH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             BUSY
);

`ifdef SHIFT_SEQ_QUAD_STEP_EN
    localparam int STEPS = 4;
`else
    localparam int STEPS = 1;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;

    logic [WIDTH-1:0] chain [0:STEPS];
    logic [WIDTH-1:0] step_data;
    logic [AMT_W-1:0] step_cnt;

    assign chain[0] = data_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        shift_one_step #(.WIDTH(WIDTH)) u_step (
            .data_in  (chain[i]),
            .dir      (dir_q),
            .fill     (fill_q),
            .data_out (chain[i+1])
        );
    end

`ifdef SHIFT_SEQ_QUAD_STEP_EN
    // take the four-bit result while at least four positions remain
    always_comb begin
        step_data = (cnt_q >= AMT_W'(4)) ? chain[4] : chain[1];
        step_cnt  = (cnt_q >= AMT_W'(4)) ? AMT_W'(4) : AMT_W'(1);
    end
`else
    // strictly one position per cycle
    always_comb begin
        step_data = chain[1];
        step_cnt  = AMT_W'(1);
    end
`endif

    // state and datapath registers; reset discards any in-flight request
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
        end
    end

    // next state: zero-amount requests go straight to DONE; SHIFT ends when the counter runs out
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IN_VALID ? ((IN_AMT == '0) ? DONE : SHIFT) : IDLE;
            SHIFT:   state_d = (cnt_q == step_cnt) ? DONE : SHIFT;
            DONE:    state_d = OUT_READY ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: capture on accept, step while shifting, hold otherwise
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        fill_d = fill_q;
        if (state_q == IDLE && IN_VALID) begin
            data_d = IN_DATA;
            cnt_d  = IN_AMT;
            dir_d  = SH_DIR;
            fill_d = ARITH & SH_DIR & IN_DATA[WIDTH-1];
        end else if (state_q == SHIFT) begin
            data_d = step_data;
            cnt_d  = cnt_q - step_cnt;
        end
    end

    // outputs decoded from state; result is masked to 0 outside DONE
    always_comb begin
        IN_READY  = (state_q == IDLE);
        OUT_VALID = (state_q == DONE);
        BUSY      = (state_q != IDLE);
        OUT_DATA  = (state_q == DONE) ? data_q : '0;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed self-checking bench against an arithmetic shift model
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amt = '0;
    logic        sh_dir = 1'b0;
    logic        arith = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_sequencer dut (
        .CLK       (clk),
        .RESET     (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DATA   (in_data),
        .IN_AMT    (in_amt),
        .SH_DIR    (sh_dir),
        .ARITH     (arith),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] d, input int n, input logic dir, input logic ar);
        if (!dir) return d << n;
        if (ar) return $unsigned($signed(d) >>> n);
        return d >> n;
    endfunction

    function automatic int model_lat(input int n);
`ifdef SHIFT_SEQ_QUAD_STEP_EN
        return 1 + n / 4 + n % 4;
`else
        return 1 + n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one complete transaction: accept, wait for result, hold under backpressure, release
    task automatic do_op(input logic [31:0] d, input int n, input logic dir, input logic ar, input int hold);
        logic [31:0] exp;
        int lat;
        exp = model(d, n, dir, ar);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = n[4:0];
        sh_dir   = dir;
        arith    = ar;
        tick();
        in_valid = 1'($urandom);
        in_data  = $urandom;
        in_amt   = 5'($urandom);
        sh_dir   = 1'($urandom);
        arith    = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin
            checks++;
            if (out_data !== 32'h0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL shifting_outputs data %h ready %b busy %b want 0/0/1", out_data, in_ready, busy);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat != model_lat(n)) begin
            errors++;
            $display("FAIL latency n=%0d got %0d want %0d", n, lat, model_lat(n));
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL result d=%h n=%0d dir=%b ar=%b got %h v%b r%b want %h", d, n, dir, ar, out_data, out_valid, in_ready, exp);
            end
            if (h < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL release ready %b valid %b busy %b data %h want 1/0/0/0", in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset ready %b valid %b busy %b data %h want 1/0/0/0", in_ready, out_valid, busy, out_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        do_op(32'h0000_0001, 4, 1'b0, 1'b0, 0);
        do_op(32'h8000_0000, 31, 1'b1, 1'b1, 0);
        do_op(32'hF000_000F, 8, 1'b1, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 0, 1'b1, 1'b1, 0);
        do_op(32'hFFFF_FFFF, 31, 1'b0, 1'b0, 0);
        do_op(32'h8765_4321, 31, 1'b1, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        do_op(32'h1234_5678, 3, 1'b1, 1'b1, 3);
        do_op(32'hA5A5_0000, 7, 1'b0, 1'b1, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_op($urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data  = 32'hCAFE_F00D;
        in_amt   = 5'd20;
        sh_dir   = 1'b1;
        arith    = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset ready %b valid %b busy %b data %h want 1/0/0/0", in_ready, out_valid, busy, out_data);
        end
        do_op(32'h0F0F_0F0F, 5, 1'b0, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_op($urandom, i * 5, 1'(i), 1'(i >> 1), 0);
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
